// File: rtl/iterative_multiplier.sv
// Unsigned shift-and-add multiplier, one multiplier bit per clock, with an E/done handshake.
// state | meaning
// RESET | post-reset, always advances to S1
// S1    | idle, waiting for E=1 to capture A/B
// S2    | iterating, N edges
// S3    | done, product held until E drops
module iterative_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           E,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic [2*N-1:0] P,
  output logic           done
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] C_INIT = CW'(N - 1);

  typedef enum logic [1:0] {
    RESET = 2'd0,
    S1    = 2'd1,
    S2    = 2'd2,
    S3    = 2'd3
  } state_t;

  state_t          state;
  logic [2*N-1:0]  ma;
  logic [N-1:0]    mb;
  logic [CW-1:0]   c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RESET;
      P     <= '0;
      done  <= 1'b0;
      ma    <= '0;
      mb    <= '0;
      c     <= '0;
    end else begin
      case (state)
        RESET: begin
          state <= S1;
          done  <= 1'b0;
        end
        S1: begin
          if (E) begin
            ma    <= {{N{1'b0}}, A};
            mb    <= B;
            P     <= '0;
            c     <= C_INIT;
            state <= S2;
          end
        end
        S2: begin
          // fixed N iterations, no early exit when mb runs out of ones
          if (mb[0]) P <= P + ma;
          ma <= ma << 1;
          mb <= mb >> 1;
          if (c == '0) begin
            state <= S3;
            done  <= 1'b1;
          end else begin
            c <= c - 1'b1;
          end
        end
        S3: begin
          if (!E) begin
            state <= S1;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= RESET;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Directed and random checks of iterative_multiplier at N=8 and N=4 sharing one E/reset.
module tb_iterative_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        e;
  logic [7:0]  a, b;
  logic [15:0] p8;
  logic        done8;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign a4 = a[3:0];
  assign b4 = b[3:0];

  iterative_multiplier #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .E(e), .A(a), .B(b), .P(p8), .done(done8)
  );

  iterative_multiplier #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .E(e), .A(a4), .B(b4), .P(p4), .done(done4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // one-cycle E pulse; latency counted with the start edge as edge 1
  task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input bit disturb);
    int          lat8, lat4;
    logic [15:0] r8;
    logic [7:0]  r4;
    lat8 = 0; lat4 = 0; r8 = '0; r4 = '0;
    @(negedge clk);
    a = ai; b = bi; e = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 1) e = 1'b0;
      if (disturb && k <= 6) begin
        a = 8'($urandom);
        b = 8'($urandom);
        if (k == 2) e = 1'b1;
        if (k == 3) e = 1'b0;
      end
      if (done8 && lat8 == 0) begin
        lat8 = k; r8 = p8;
      end else if (lat8 != 0 && k == lat8 + 1) begin
        chk("done8_drop", 32'(done8), 32'd0);
      end
      if (done4 && lat4 == 0) begin
        lat4 = k; r4 = p4;
      end else if (lat4 != 0 && k == lat4 + 1) begin
        chk("done4_drop", 32'(done4), 32'd0);
      end
    end
    chk("lat8", 32'(lat8), 32'd9);
    chk("p8", 32'(r8), 32'(16'(ai) * 16'(bi)));
    chk("lat4", 32'(lat4), 32'd5);
    chk("p4", 32'(r4), 32'(8'(ai[3:0]) * 8'(bi[3:0])));
  endtask

  initial begin
    reset = 1'b0; e = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_p8", 32'(p8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_p4", 32'(p4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    run_op(8'd13, 8'd11, 1'b0);
    run_op(8'd255, 8'd255, 1'b0);
    run_op(8'd0, 8'd200, 1'b0);
    run_op(8'd200, 8'd0, 1'b0);

    // E held through S3
    @(negedge clk);
    a = 8'd13; b = 8'd11; e = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 8) chk("hold_done_early", 32'(done8), 32'd0);
    end
    chk("hold_done_rise", 32'(done8), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_done8", 32'(done8), 32'd1);
      chk("hold_p8", 32'(p8), 32'd143);
      chk("hold_done4", 32'(done4), 32'd1);
      chk("hold_p4", 32'(p4), 32'd143);
    end
    e = 1'b0;
    @(negedge clk);
    chk("exit_done8", 32'(done8), 32'd0);
    chk("exit_p8", 32'(p8), 32'd143);
    run_op(8'd7, 8'd6, 1'b0);

    // operand and E changes during S2 are ignored
    run_op(8'd99, 8'd201, 1'b1);
    run_op(8'd15, 8'd15, 1'b1);

    // async reset in the middle of S2
    @(negedge clk);
    a = 8'd255; b = 8'd255; e = 1'b1;
    @(negedge clk);
    e = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_p8_nonzero", 32'(p8 != 16'd0), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_p8", 32'(p8), 32'd0);
    chk("arst_done8", 32'(done8), 32'd0);
    chk("arst_p4", 32'(p4), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(8'd3, 8'd5, 1'b0);

    // async reset while holding in S3
    @(negedge clk);
    a = 8'd9; b = 8'd9; e = 1'b1;
    repeat (10) @(negedge clk);
    chk("s3_done8", 32'(done8), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("s3_arst_done8", 32'(done8), 32'd0);
    chk("s3_arst_p8", 32'(p8), 32'd0);
    e = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_op(8'd255, 8'd1, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
